video_pattern_gen: RTL and testbench

//  Self-timed video source: generates raster timing plus a selectable test pattern
//  on the same parallel RGB/dv/hs/vs interface that hdmi_tx consumes.

---
 rtl/video_pattern_gen_pkg.sv | 68 ++++++
 rtl/video_pattern_gen_timing.sv | 79 +++++++
 rtl/video_pattern_gen.sv | 186 ++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// video_pattern_gen_pkg
//   Shared definitions for the self-timed video source.
//   - Default 720p raster timing.
//   - Test pattern codes.
//   - RGB pixel type and common colours.
//   - Helpers for counter sizing and colour-bar lookup.
//   hdmi_top and any filters placed in front of hdmi_tx can import this
//   package to agree on the raster geometry.
// ---------------------------------------------------------------------------
package video_pattern_gen_pkg;

    // 1280x720 @ 60 Hz raster, CEA-861 style porches
    localparam int TIM_H_ACTIVE = 1280;
    localparam int TIM_H_FP     = 110;
    localparam int TIM_H_SYNC   = 40;
    localparam int TIM_H_BP     = 220;
    localparam int TIM_V_ACTIVE = 720;
    localparam int TIM_V_FP     = 5;
    localparam int TIM_V_SYNC   = 5;
    localparam int TIM_V_BP     = 20;

    // Side length of the moving box pattern, in pixels and lines
    localparam int BOX_SIZE = 64;

    // Counters must hold the box edge arithmetic: a left edge of up to
    // 255*4 = 1020 plus the box size still fits in 11 bits.
    localparam int MIN_CNT_W = 11;

    // Pattern codes; anything above PAT_BOX renders solid black
    typedef enum logic [2:0] {
        PAT_BARS  = 3'd0,
        PAT_RAMP  = 3'd1,
        PAT_CHECK = 3'd2,
        PAT_BOX   = 3'd3
    } pattern_e;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{red: 8'h00, green: 8'h00, blue: 8'h00};
    localparam rgb_t RGB_WHITE = '{red: 8'hFF, green: 8'hFF, blue: 8'hFF};

    // Width of the raster counters: wide enough for either total and
    // never narrower than MIN_CNT_W.
    function automatic int cnt_width(input int h_tot, input int v_tot);
        int w;
        w = MIN_CNT_W;
        if ($clog2(h_tot) > w) w = $clog2(h_tot);
        if ($clog2(v_tot) > w) w = $clog2(v_tot);
        return w;
    endfunction

    // Colour bar lookup. The classic order white, yellow, cyan, green,
    // magenta, red, blue, black falls out of the index bits directly:
    // red is off for bars 2,3,6,7; green off for 4..7; blue off for odd bars.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.red   = {8{~idx[1]}};
        c.green = {8{~idx[2]}};
        c.blue  = {8{~idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/video_pattern_gen_timing.sv
// ---------------------------------------------------------------------------
// video_pattern_gen_timing
//   Raster timing generator: horizontal/vertical counters plus the region
//   decodes derived from them. All outputs are combinational views of the
//   current counter state; the parent registers them.
//
//   Ports
//     i_clk          pixel clock
//     i_rst          synchronous active-high reset
//     i_en           1 = run raster, 0 = counters held at origin
//     o_x, o_y       current pixel column / line
//     o_dv           inside the active picture
//     o_hs           inside the horizontal sync region (active high)
//     o_vs           inside the vertical sync lines (active high)
//     o_frame_start  counters sit at (0,0) while running
// ---------------------------------------------------------------------------
module video_pattern_gen_timing
    import video_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = TIM_H_ACTIVE,
    parameter int H_FP     = TIM_H_FP,
    parameter int H_SYNC   = TIM_H_SYNC,
    parameter int H_BP     = TIM_H_BP,
    parameter int V_ACTIVE = TIM_V_ACTIVE,
    parameter int V_FP     = TIM_V_FP,
    parameter int V_SYNC   = TIM_V_SYNC,
    parameter int V_BP     = TIM_V_BP,
    parameter int CNT_W    = MIN_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_dv,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    // Raster counters. Disabling the raster parks them at the origin so
    // that re-enabling always restarts a clean frame at (0,0).
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Region decodes. Vertical sync depends only on the line count, so it
    // naturally covers whole lines and changes together with the h wrap.
    assign o_x           = r_h;
    assign o_y           = r_v;
    assign o_dv          = (r_h < H_ACT_END) && (r_v < V_ACT_END);
    assign o_hs          = (r_h >= HS_START) && (r_h < HS_END);
    assign o_vs          = (r_v >= VS_START) && (r_v < VS_END);
    assign o_frame_start = i_en && (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//   Self-timed video source producing raster timing and a selectable test
//   pattern on the same parallel RGB/dv/hs/vs interface that hdmi_tx uses.
//   Every output is registered, one clock behind the raster counters.
//
//   Ports
//     i_clk          pixel clock
//     i_rst          synchronous active-high reset
//     i_en           1 = run raster, 0 = idle with counters at origin
//     i_pattern_sel  pattern code, taken only at the start of a frame
//                    0 bars, 1 grey ramp, 2 checkerboard, 3 moving box,
//                    4..7 solid black
//     o_tx_red       red pixel data
//     o_tx_green     green pixel data
//     o_tx_blue      blue pixel data
//     o_tx_dv        high during active pixels
//     o_tx_hs        horizontal sync, active level HS_POL
//     o_tx_vs        vertical sync, active level VS_POL
//     o_frame_start  one-cycle pulse alongside pixel (0,0)
// ---------------------------------------------------------------------------
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = TIM_H_ACTIVE,
    parameter int H_FP     = TIM_H_FP,
    parameter int H_SYNC   = TIM_H_SYNC,
    parameter int H_BP     = TIM_H_BP,
    parameter int V_ACTIVE = TIM_V_ACTIVE,
    parameter int V_FP     = TIM_V_FP,
    parameter int V_SYNC   = TIM_V_SYNC,
    parameter int V_BP     = TIM_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [2:0] i_pattern_sel,
    output logic [7:0] o_tx_red,
    output logic [7:0] o_tx_green,
    output logic [7:0] o_tx_blue,
    output logic       o_tx_dv,
    output logic       o_tx_hs,
    output logic       o_tx_vs,
    output logic       o_frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W = cnt_width(H_TOT, V_TOT);
    localparam int BAR_W = H_ACTIVE / 8;

    localparam bit HS_IDLE = ~HS_POL;
    localparam bit VS_IDLE = ~VS_POL;

    localparam logic [CNT_W-1:0] BOX_LEN = CNT_W'(BOX_SIZE);

    // Raster state from the timing generator
    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_y;
    logic             w_dv;
    logic             w_hs;
    logic             w_vs;
    logic             w_frame_start;

    // Per-frame pattern state
    logic [2:0]       r_sel;
    logic [7:0]       r_frame_cnt;
    logic [9:0]       r_box_left;

    // Output register stage
    rgb_t             r_rgb;
    logic             r_dv;
    logic             r_hs;
    logic             r_vs;
    logic             r_frame_start;

    // Pattern datapath
    logic [2:0]       w_sel;
    logic [9:0]       w_box_left;
    logic [CNT_W-1:0] w_box_lo;
    logic [CNT_W-1:0] w_box_hi;
    logic             w_in_box;
    logic [2:0]       w_bar_idx;
    rgb_t             w_rgb;

    video_pattern_gen_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .o_x           (w_x),
        .o_y           (w_y),
        .o_dv          (w_dv),
        .o_hs          (w_hs),
        .o_vs          (w_vs),
        .o_frame_start (w_frame_start)
    );

    // At pixel (0,0) the frame's pattern and box position are being latched
    // on this very edge, so that pixel must already use the incoming values
    // rather than last frame's registered copies.
    assign w_sel      = w_frame_start ? i_pattern_sel : r_sel;
    assign w_box_left = w_frame_start ? {r_frame_cnt, 2'b00} : r_box_left;

    assign w_box_lo = CNT_W'(w_box_left);
    assign w_box_hi = w_box_lo + BOX_LEN;
    assign w_in_box = (w_x >= w_box_lo) && (w_x < w_box_hi) && (w_y < BOX_LEN);

    // Bar index by threshold comparison instead of a divide. Any pixels
    // left over when H_ACTIVE is not a multiple of 8 stay in bar 7.
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_x >= CNT_W'(k * BAR_W)) begin
                w_bar_idx = 3'(k);
            end
        end
    end

    // Pixel colour for the current raster position; blanking is always black
    always_comb begin
        w_rgb = RGB_BLACK;
        if (w_dv) begin
            case (w_sel)
                PAT_BARS:  w_rgb = bar_colour(w_bar_idx);
                PAT_RAMP:  w_rgb = '{red: w_x[7:0], green: w_x[7:0], blue: w_x[7:0]};
                PAT_CHECK: if (w_x[5] ^ w_y[5]) w_rgb = RGB_WHITE;
                PAT_BOX:   if (w_in_box) w_rgb = RGB_WHITE;
                default:   w_rgb = RGB_BLACK;
            endcase
        end
    end

    // Output registers and per-frame state. Dropping enable idles the
    // outputs but keeps the frame counter and pattern selection, so the box
    // keeps moving from where it was; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rgb         <= RGB_BLACK;
            r_dv          <= 1'b0;
            r_hs          <= HS_IDLE;
            r_vs          <= VS_IDLE;
            r_frame_start <= 1'b0;
            r_sel         <= 3'd0;
            r_frame_cnt   <= 8'd0;
            r_box_left    <= 10'd0;
        end else if (!i_en) begin
            r_rgb         <= RGB_BLACK;
            r_dv          <= 1'b0;
            r_hs          <= HS_IDLE;
            r_vs          <= VS_IDLE;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb;
            r_dv          <= w_dv;
            r_hs          <= w_hs ? HS_POL : HS_IDLE;
            r_vs          <= w_vs ? VS_POL : VS_IDLE;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                r_sel       <= i_pattern_sel;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_box_left  <= w_box_left;
            end
        end
    end

    assign o_tx_red      = r_rgb.red;
    assign o_tx_green    = r_rgb.green;
    assign o_tx_blue     = r_rgb.blue;
    assign o_tx_dv       = r_dv;
    assign o_tx_hs       = r_hs;
    assign o_tx_vs       = r_vs;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
//   Scoreboard bench for video_pattern_gen on a reduced 24x12 raster.
//   The reference model tracks time since the raster was started and derives
//   the pixel position, region flags and pattern colour from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

    localparam int HA    = 16;
    localparam int HF    = 2;
    localparam int HSY   = 3;
    localparam int HB    = 3;
    localparam int VA    = 8;
    localparam int VF    = 1;
    localparam int VSY   = 2;
    localparam int VB    = 1;
    localparam int HT    = HA + HF + HSY + HB;
    localparam int VT    = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    localparam logic [23:0] BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] patternSel = 3'd0;

    logic [7:0] txRed;
    logic [7:0] txGreen;
    logic [7:0] txBlue;
    logic       txDv;
    logic       txHs;
    logic       txVs;
    logic       frameStart;

    // Expected outputs packed as {rgb, dv, hs, vs, frame_start}
    logic [27:0] expQ[$];

    int nVectors     = 0;
    int nMiscompares = 0;

    // Reference model state
    int runT      = 0;
    int frameCnt  = 0;
    int selQ      = 0;
    int boxLeft   = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HSY),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VSY),
        .V_BP     (VB),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_pattern_sel (patternSel),
        .o_tx_red      (txRed),
        .o_tx_green    (txGreen),
        .o_tx_blue     (txBlue),
        .o_tx_dv       (txDv),
        .o_tx_hs       (txHs),
        .o_tx_vs       (txVs),
        .o_frame_start (frameStart)
    );

    // Pixel the source should present for raster position (h,v)
    function automatic logic [27:0] pixelOut(input int h, input int v, input int sel,
                                             input int box, input bit fs);
        bit          dv;
        bit          hs;
        bit          vs;
        int          bar;
        logic [7:0]  grey;
        logic [23:0] rgb;
        dv  = (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HSY);
        vs  = (v >= VA + VF) && (v < VA + VF + VSY);
        rgb = 24'h000000;
        if (dv) begin
            case (sel)
                0: begin
                    bar = h / (HA / 8);
                    if (bar > 7) bar = 7;
                    rgb = BAR_COLOURS[bar];
                end
                1: begin
                    grey = 8'(h % 256);
                    rgb  = {grey, grey, grey};
                end
                2: if (((h / 32) % 2) != ((v / 32) % 2)) rgb = 24'hFFFFFF;
                3: if (h >= box && h < box + 64 && v < 64) rgb = 24'hFFFFFF;
                default: rgb = 24'h000000;
            endcase
        end
        return {rgb, dv, hs, vs, fs};
    endfunction

    // Drive one clock's worth of inputs and queue what the next edge must produce
    task automatic applyStimulus(input bit rstIn, input bit enIn, input logic [2:0] selIn);
        int p;
        logic [27:0] expected;
        @(negedge clk);
        rst        = rstIn;
        en         = enIn;
        patternSel = selIn;
        if (rstIn) begin
            expected = 28'h0;
            runT     = 0;
            frameCnt = 0;
            selQ     = 0;
            boxLeft  = 0;
        end else if (!enIn) begin
            expected = 28'h0;
            runT     = 0;
        end else begin
            p = runT % FRAME;
            if (p == 0) begin
                selQ     = int'(selIn);
                boxLeft  = (frameCnt % 256) * 4;
                frameCnt = frameCnt + 1;
            end
            expected = pixelOut(p % HT, p / HT, selQ, boxLeft, p == 0);
            runT     = runT + 1;
        end
        expQ.push_back(expected);
    endtask

    task automatic checkOutput(input logic [27:0] expected);
        logic [27:0] actual;
        actual   = {txRed, txGreen, txBlue, txDv, txHs, txVs, frameStart};
        nVectors = nVectors + 1;
        if (actual !== expected) begin
            nMiscompares = nMiscompares + 1;
            $display("[TB] FAIL pixel vec %0d @%0t: got rgb=%06h dv=%b hs=%b vs=%b fs=%b, want rgb=%06h dv=%b hs=%b vs=%b fs=%b",
                     nVectors, $time, actual[27:4], actual[3], actual[2], actual[1], actual[0],
                     expected[27:4], expected[3], expected[2], expected[1], expected[0]);
        end
    endtask

    // Monitor: the source presents a new output word on every clock
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        int holdRst;
        int holdEn;
        logic [2:0] rndSel;

        // Reset held with enable already high
        repeat (5) applyStimulus(1'b1, 1'b1, 3'd0);

        // Free run on colour bars; selection switches to checkerboard
        // 100 clocks into the fourth frame and must only take effect on the fifth
        for (int c = 0; c < 5 * FRAME; c++) begin
            applyStimulus(1'b0, 1'b1, (c >= 3 * FRAME + 100) ? 3'd2 : 3'd0);
        end

        // Enable dropped 150 clocks into a frame for 10 clocks
        for (int c = 0; c < 150; c++) applyStimulus(1'b0, 1'b1, 3'd2);
        for (int c = 0; c < 10; c++)  applyStimulus(1'b0, 1'b0, 3'd1);

        // Restart into the grey ramp, then several frames of moving box
        for (int c = 0; c < 2 * FRAME; c++) applyStimulus(1'b0, 1'b1, 3'd1);
        for (int c = 0; c < 6 * FRAME; c++) applyStimulus(1'b0, 1'b1, 3'd3);

        // Randomised pattern changes, enable drops and occasional resets
        holdRst = 0;
        holdEn  = 0;
        rndSel  = 3'd3;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) rndSel = 3'($urandom_range(0, 7));
            if (holdRst > 0) holdRst = holdRst - 1;
            else if ($urandom_range(0, 999) == 0) holdRst = $urandom_range(1, 3);
            if (holdEn > 0) holdEn = holdEn - 1;
            else if ($urandom_range(0, 499) == 0) holdEn = $urandom_range(1, 20);
            applyStimulus(holdRst > 0, !(holdEn > 0), rndSel);
        end

        // Let the monitor drain the scoreboard, bounded
        for (int w = 0; w < 10 && expQ.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() > 0) begin
            nMiscompares = nMiscompares + 1;
            $display("[TB] FAIL drain: got %0d entries left, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
